// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline sequencer with load-use interlock, forwarding selects, sticky halt and counters
module pipe_ctrl #(
  parameter int STAGES = 4,
  parameter int DW = 32,
  parameter int PCW = 16,
  parameter int RW = 3,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [PCW-1:0] in_pc,
  input  logic [DW-1:0]  in_payload,
  input  logic [RW-1:0]  in_src_a,
  input  logic [RW-1:0]  in_src_b,
  input  logic           in_use_a,
  input  logic           in_use_b,
  input  logic [RW-1:0]  in_dst,
  input  logic           in_wen,
  input  logic           in_load,
  input  logic           in_halt,
  input  logic           redirect,
  output logic [1:0]     fwd_a,
  output logic [1:0]     fwd_b,
  output logic           out_valid,
  output logic [PCW-1:0] out_pc,
  output logic [DW-1:0]  out_payload,
  output logic [RW-1:0]  out_dst,
  output logic           out_wen,
  output logic           stall,
  output logic           halted,
  output logic [PCW-1:0] halt_pc,
  output logic [CW-1:0]  retired,
  output logic [CW-1:0]  stalls
);
  typedef struct packed {
    logic           v;
    logic [PCW-1:0] pc;
    logic [DW-1:0]  pl;
    logic [RW-1:0]  sa;
    logic [RW-1:0]  sb;
    logic [RW-1:0]  dst;
    logic           ua;
    logic           ub;
    logic           wen;
    logic           ld;
    logic           hl;
  } stage_t;

  stage_t st [STAGES];
  stage_t nx [STAGES];
  stage_t inc;
  logic redir, hazard, busy;

  assign redir = redirect && st[1].v;
  assign hazard = st[0].v && st[1].v && st[1].ld && st[1].wen &&
                  ((st[0].ua && st[0].sa == st[1].dst) || (st[0].ub && st[0].sb == st[1].dst));
  assign stall = hazard && !redir;
  assign in_ready = rst && !halted && !busy && !stall && !redir;

  assign fwd_a = (st[2].v && st[2].wen && !st[2].ld && st[2].dst == st[1].sa) ? 2'd1 :
                 (st[3].v && st[3].wen && st[3].dst == st[1].sa) ? 2'd2 : 2'd0;
  assign fwd_b = (st[2].v && st[2].wen && !st[2].ld && st[2].dst == st[1].sb) ? 2'd1 :
                 (st[3].v && st[3].wen && st[3].dst == st[1].sb) ? 2'd2 : 2'd0;

  assign out_valid   = st[STAGES-1].v;
  assign out_pc      = st[STAGES-1].pc;
  assign out_payload = st[STAGES-1].pl;
  assign out_dst     = st[STAGES-1].dst;
  assign out_wen     = st[STAGES-1].wen;

  // a valid halt anywhere in flight blocks every younger offer
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < STAGES; k++) busy = busy | (st[k].v & st[k].hl);
  end

  // next stage contents: stall holds stage 0 and bubbles stage 1, redirect squashes stage 0
  always_comb begin
    inc = '0;
    if (in_valid && in_ready)
      inc = '{v: 1'b1, pc: in_pc, pl: in_payload, sa: in_src_a, sb: in_src_b, dst: in_dst,
              ua: in_use_a, ub: in_use_b, wen: in_wen, ld: in_load, hl: in_halt};
    nx[0] = stall ? st[0] : inc;
    nx[1] = (stall || redir) ? '0 : st[0];
    for (int k = 2; k < STAGES; k++) nx[k] = st[k-1];
  end

  // stage registers, emptied every cycle once halted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      for (int k = 0; k < STAGES; k++) st[k] <= '0;
    else
      for (int k = 0; k < STAGES; k++) st[k] <= halted ? '0 : nx[k];
  end

  // retire/stall counters and sticky halt capture, all frozen after halt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= '0;
      stalls  <= '0;
      halted  <= 1'b0;
      halt_pc <= '0;
    end else if (!halted) begin
      if (st[STAGES-1].v) retired <= retired + 1'b1;
      if (st[STAGES-1].v && st[STAGES-1].hl) begin
        halted  <= 1'b1;
        halt_pc <= st[STAGES-1].pc;
      end
      if (stall && stalls != '1) stalls <= stalls + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against an instruction-list model
module tb_pipe_ctrl;
  localparam int S = 4, DW = 32, PCW = 16, RW = 3, CW = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 0, in_use_a = 0, in_use_b = 0, in_wen = 0, in_load = 0, in_halt = 0, redirect = 0;
  logic [PCW-1:0] in_pc = '0;
  logic [DW-1:0] in_payload = '0;
  logic [RW-1:0] in_src_a = '0, in_src_b = '0, in_dst = '0;
  logic in_ready, out_valid, out_wen, stall, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [PCW-1:0] out_pc, halt_pc;
  logic [DW-1:0] out_payload;
  logic [RW-1:0] out_dst;
  logic [CW-1:0] retired, stalls;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(S), .DW(DW), .PCW(PCW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_payload(in_payload), .in_src_a(in_src_a), .in_src_b(in_src_b), .in_use_a(in_use_a),
    .in_use_b(in_use_b), .in_dst(in_dst), .in_wen(in_wen), .in_load(in_load), .in_halt(in_halt),
    .redirect(redirect), .fwd_a(fwd_a), .fwd_b(fwd_b), .out_valid(out_valid), .out_pc(out_pc),
    .out_payload(out_payload), .out_dst(out_dst), .out_wen(out_wen), .stall(stall),
    .halted(halted), .halt_pc(halt_pc), .retired(retired), .stalls(stalls));

  typedef struct {
    logic [PCW-1:0] pc;
    logic [DW-1:0] pl;
    logic [RW-1:0] sa, sb, dst;
    bit ua, ub, wen, ld, hl;
    int pos;
  } ins_t;

  ins_t q[$];
  bit m_halted;
  logic [PCW-1:0] m_hpc;
  logic [CW-1:0] m_ret, m_stalls;
  bit e_ready, e_stall, e_redir;
  int checks = 0, errors = 0;

  function automatic bit at(int p, output ins_t r);
    r = '{pc: 0, pl: 0, sa: 0, sb: 0, dst: 0, ua: 0, ub: 0, wen: 0, ld: 0, hl: 0, pos: -1};
    foreach (q[i]) if (q[i].pos == p) begin r = q[i]; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic predict();
    ins_t a, b;
    bit h0, h1, hz, busy;
    h0 = at(0, a);
    h1 = at(1, b);
    e_redir = redirect && h1;
    hz = h0 && h1 && b.ld && b.wen && ((a.ua && a.sa == b.dst) || (a.ub && a.sb == b.dst));
    e_stall = hz && !e_redir;
    busy = 0;
    foreach (q[i]) busy |= q[i].hl;
    e_ready = rst && !m_halted && !busy && !e_stall && !e_redir;
  endtask

  task automatic update();
    ins_t n[$];
    ins_t r;
    if (m_halted) begin q.delete(); return; end
    foreach (q[i]) begin
      r = q[i];
      if (r.pos == S - 1) begin
        m_ret++;
        if (r.hl) begin m_halted = 1; m_hpc = r.pc; end
      end else if (!(r.pos == 0 && e_redir)) begin
        if (!(r.pos == 0 && e_stall)) r.pos++;
        n.push_back(r);
      end
    end
    if (e_stall && m_stalls != '1) m_stalls++;
    if (in_valid && e_ready)
      n.push_back('{pc: in_pc, pl: in_payload, sa: in_src_a, sb: in_src_b, dst: in_dst, ua: in_use_a,
                    ub: in_use_b, wen: in_wen, ld: in_load, hl: in_halt, pos: 0});
    q = n;
  endtask

  task automatic cycle();
    ins_t b, c, d;
    bit ov;
    int fa, fb;
    #1;
    predict();
    chk("in_ready", in_ready, e_ready);
    chk("stall", stall, e_stall);
    ov = at(S - 1, d);
    chk("out_valid", out_valid, ov);
    if (ov) begin
      chk("out_pc", out_pc, d.pc);
      chk("out_payload", out_payload, d.pl);
      chk("out_dst", out_dst, d.dst);
      chk("out_wen", out_wen, d.wen);
    end
    chk("retired", retired, m_ret);
    chk("stalls", stalls, m_stalls);
    chk("halted", halted, m_halted);
    chk("halt_pc", halt_pc, m_hpc);
    if (at(1, b)) begin
      fa = 0;
      fb = 0;
      if (at(3, d) && d.wen) begin
        if (d.dst == b.sa) fa = 2;
        if (d.dst == b.sb) fb = 2;
      end
      if (at(2, c) && c.wen && !c.ld) begin
        if (c.dst == b.sa) fa = 1;
        if (c.dst == b.sb) fb = 1;
      end
      chk("fwd_a", fwd_a, fa);
      chk("fwd_b", fwd_b, fb);
    end
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int pc, input int sa, input bit ua, input int sb, input bit ub,
                       input int dst, input bit wen, input bit ld, input bit hl, input bit rd);
    in_valid = v; in_pc = PCW'(pc); in_payload = $urandom;
    in_src_a = RW'(sa); in_use_a = ua; in_src_b = RW'(sb); in_use_b = ub;
    in_dst = RW'(dst); in_wen = wen; in_load = ld; in_halt = hl; redirect = rd;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 0; in_valid = 0; redirect = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_retired", retired, 0);
    chk("rst_stalls", stalls, 0);
    chk("rst_halted", halted, 0);
    q.delete();
    m_halted = 0; m_hpc = '0; m_ret = '0; m_stalls = '0;
    @(negedge clk);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_payload", out_payload, 0);
    chk("rst_halt_pc", halt_pc, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    rst = 1;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 6; i++) drive(1, i, 0, 0, 0, 0, i, 1, 0, 0, 0);
    idle(4);
    chk("stream_retired", retired, 6);
    chk("stream_stalls", stalls, 0);

    do_reset();
    drive(1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    drive(1, 1, 2, 1, 0, 0, 4, 1, 0, 0, 0);
    idle(6);
    chk("loaduse_stalls", stalls, 1);
    chk("loaduse_retired", retired, 2);

    do_reset();
    drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 3, 1, 5, 1, 0, 0, 0);
    idle(5);
    chk("fwd_stalls", stalls, 0);

    do_reset();
    drive(1, 4, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    drive(1, 5, 1, 1, 0, 0, 6, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(5);
    chk("redir_retired", retired, 1);
    chk("redir_stalls", stalls, 0);

    do_reset();
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 8; i < 18; i++) drive(1, i, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("halt_halted", halted, 1);
    chk("halt_pc7", halt_pc, 7);
    chk("halt_retired", retired, 1);

    do_reset();
    for (int i = 0; i < 5; i++) drive(1, i, 0, 0, 0, 0, i, 1, 0, 0, 0);
    do_reset();

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, i, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
            1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            0, $urandom_range(0, 7) == 0);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
